// File: rtl/ultrasonic_ranger_if.sv
// ultrasonic_ranger_if: request/result handshake and sensor pins of the ranging controller
interface ultrasonic_ranger_if #(parameter int CNT_W = 16);
    logic start, echo, trigger, busy, done, timeout;
    logic [CNT_W-1:0] echo_us;
    modport master(output start, echo, input trigger, busy, done, timeout, echo_us);
    modport slave(input start, echo, output trigger, busy, done, timeout, echo_us);
endinterface

// File: rtl/ultrasonic_ranger_ctrl.sv
// ultrasonic_ranger_ctrl: one trigger/echo ranging cycle per start, width in 1 us ticks or timeout
module ultrasonic_ranger_ctrl #(
    parameter int TICK_DIV    = 100,
    parameter int TRIG_US     = 10,
    parameter int RISE_TO_US  = 5000,
    parameter int ECHO_MAX_US = 30000,
    parameter int HOLDOFF_US  = 60000,
    parameter int CNT_W       = 16
) (
    input logic clk,
    input logic rst,
    ultrasonic_ranger_if.slave bus
);
    localparam int PRE_W = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0] TRIG_LAST = CNT_W'(TRIG_US - 1);
    localparam logic [CNT_W-1:0] RISE_LAST = CNT_W'(RISE_TO_US - 1);
    localparam logic [CNT_W-1:0] ECHO_LAST = CNT_W'(ECHO_MAX_US - 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_US - 1);
    localparam logic [CNT_W-1:0] ECHO_MAX  = CNT_W'(ECHO_MAX_US);
    typedef enum logic [2:0] {IDLE, TRIG, WAIT_RISE, MEASURE, HOLDOFF} state_t;
    state_t state, nxt;
    logic [PRE_W-1:0] pre;
    logic [CNT_W-1:0] cnt, cnt_inc, fin_val;
    logic echo_m, echo_s, echo_q, tick, rise, fall, fin, fin_to;
    assign tick = pre == PRE_LAST;
    assign rise = echo_s & ~echo_q;
    assign fall = ~echo_s & echo_q;
    assign cnt_inc = &cnt ? cnt : cnt + CNT_W'(1);
    assign bus.trigger = state == TRIG;
    assign bus.busy = state != IDLE;
    // A fall on a tick boundary completes that tick, so it is counted before reporting
    always_comb begin
        nxt = state;
        fin = 1'b0;
        fin_to = 1'b0;
        fin_val = '0;
        case (state)
            IDLE: nxt = bus.start ? TRIG : IDLE;
            TRIG: nxt = (tick && cnt == TRIG_LAST) ? WAIT_RISE : TRIG;
            WAIT_RISE:
                if (rise) nxt = MEASURE;
                else if (tick && cnt == RISE_LAST) begin
                    nxt = HOLDOFF;
                    fin = 1'b1;
                    fin_to = 1'b1;
                end
            MEASURE:
                if (tick && cnt == ECHO_LAST) begin
                    nxt = HOLDOFF;
                    fin = 1'b1;
                    fin_to = 1'b1;
                    fin_val = ECHO_MAX;
                end else if (fall) begin
                    nxt = HOLDOFF;
                    fin = 1'b1;
                    fin_val = tick ? cnt_inc : cnt;
                end
            HOLDOFF: nxt = (tick && cnt == HOLD_LAST) ? IDLE : HOLDOFF;
            default: nxt = IDLE;
        endcase
    end
    // Every state change restarts the prescaler so intervals begin on a tick boundary
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            pre <= '0;
            cnt <= '0;
            {echo_q, echo_s, echo_m} <= 3'b000;
            bus.done <= 1'b0;
            bus.timeout <= 1'b0;
            bus.echo_us <= '0;
        end else begin
            {echo_q, echo_s, echo_m} <= {echo_s, echo_m, bus.echo};
            state <= nxt;
            pre <= (nxt != state || tick) ? '0 : pre + PRE_W'(1);
            cnt <= (nxt != state) ? '0 : (tick ? cnt_inc : cnt);
            bus.done <= fin;
            bus.timeout <= fin_to;
            if (fin) bus.echo_us <= fin_val;
        end
    end
endmodule

// File: tb/tb_ultrasonic_ranger_ctrl.sv
// tb_ultrasonic_ranger_ctrl: random echo waveforms checked against an event-level timing model
module tb_ultrasonic_ranger_ctrl;
    localparam int DIV = 4, TRIG = 10, RTO = 50, EMAX = 200, HOLD = 20, CW = 16, N = 1400;
    localparam int W = 1 + TRIG * DIV;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic pin [N];
    int n_cmp = 0, n_bad = 0, prev_eu = 0;
    always #5 clk = ~clk;
    ultrasonic_ranger_if #(.CNT_W(CW)) bus();
    ultrasonic_ranger_ctrl #(
        .TICK_DIV(DIV), .TRIG_US(TRIG), .RISE_TO_US(RTO),
        .ECHO_MAX_US(EMAX), .HOLDOFF_US(HOLD), .CNT_W(CW)
    ) dut (.clk(clk), .rst(rst), .bus(bus));
    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask
    task automatic chk_idle(input string tag);
        chk({tag, "_trigger"}, int'(bus.trigger), 0);
        chk({tag, "_busy"}, int'(bus.busy), 0);
        chk({tag, "_done"}, int'(bus.done), 0);
        chk({tag, "_timeout"}, int'(bus.timeout), 0);
        chk({tag, "_echo_us"}, int'(bus.echo_us), 0);
    endtask
    // synchronized echo as seen by the controller in cycle c of a transaction
    function automatic logic es(input int c);
        return c >= 2 ? pin[c-2] : pin[0];
    endfunction
    // cycle 0 drives start; all offsets below are cycles relative to it
    task automatic run_txn(input int p, input int a, input int h, input bit spam, input bit hold,
                           input int rst_at);
        int rc, f, d, b, ex_to, ex_eu, tr_r, tr_f, rt, dn, dn_cnt, to_cnt, to_obs, eu_obs, bf, eu_pre;
        for (int i = 0; i < N; i++) pin[i] = (i < p) || (i >= a && i < a + h);
        rc = -1;
        f = -1;
        for (int c = W; c < W + RTO * DIV && rc < 0; c++) if (es(c) && !es(c - 1)) rc = c;
        if (rc >= 0) for (int c = rc + 1; c < rc + EMAX * DIV && f < 0; c++) if (!es(c)) f = c;
        if (rc < 0) begin
            d = W + RTO * DIV; ex_to = 1; ex_eu = 0;
        end else if (f >= 0) begin
            d = f + 1; ex_to = 0; ex_eu = (f - rc) / DIV;
        end else begin
            d = rc + EMAX * DIV + 1; ex_to = 1; ex_eu = EMAX;
        end
        b = d + HOLD * DIV;
        bus.echo = pin[0];
        bus.start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        eu_pre = int'(bus.echo_us);
        tr_r = -1; tr_f = -1; rt = -1; dn = -1; dn_cnt = 0; to_cnt = 0; to_obs = -1; eu_obs = -1; bf = -1;
        for (int t = 0; t <= b + 2; t++) begin
            if (t > 0) begin
                @(posedge clk);
                #1;
            end
            if (rst_at >= 0 && t == rst_at + 1) begin
                chk_idle("rst_mid");
                rst = 1'b0;
                prev_eu = 0;
                return;
            end
            if (bus.trigger && tr_r < 0) tr_r = t;
            else if (!bus.trigger && tr_r >= 0 && tr_f < 0) tr_f = t;
            else if (bus.trigger && tr_f >= 0 && rt < 0) rt = t;
            if (bus.timeout) to_cnt++;
            if (bus.done) begin
                dn_cnt++;
                if (dn < 0) begin
                    dn = t; to_obs = int'(bus.timeout); eu_obs = int'(bus.echo_us);
                end
            end
            if (!bus.busy && t > 0 && bf < 0) bf = t;
            bus.echo = pin[t];
            bus.start = hold || t == 0 || (spam && t > 0 && t < b && $urandom_range(0, 7) == 0);
            rst = (t == rst_at);
        end
        chk("echo_us_held", eu_pre, prev_eu);
        chk("trig_rise", tr_r, 1);
        chk("trig_fall", tr_f, W);
        chk("done_at", dn, d);
        chk("done_pulses", dn_cnt, 1);
        chk("timeout", to_obs, ex_to);
        chk("timeout_pulses", to_cnt, ex_to);
        chk("echo_us", eu_obs, ex_eu);
        chk("busy_fall", bf, b);
        chk("retrigger", rt, hold ? b + 1 : -1);
        if (hold) begin
            rst = 1'b1;
            bus.start = 1'b0;
            @(posedge clk);
            #1;
            chk_idle("rst_held");
            rst = 1'b0;
            prev_eu = 0;
        end else prev_eu = ex_eu;
    endtask
    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end
    initial begin
        int mode, p, a, h;
        bus.start = 1'b0;
        bus.echo = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_idle("reset");
        rst = 1'b0;
        run_txn(0, 61, 400, 1'b0, 1'b0, -1);
        run_txn(0, N, 0, 1'b0, 1'b0, -1);
        run_txn(300, N, 0, 1'b0, 1'b0, -1);
        run_txn(0, 50, 1000, 1'b0, 1'b0, -1);
        run_txn(0, 61, 400, 1'b1, 1'b0, -1);
        run_txn(0, 70, 123, 1'b0, 1'b1, -1);
        run_txn(0, 61, 600, 1'b0, 1'b0, 300);
        run_txn(0, 61, 400, 1'b0, 1'b0, -1);
        for (int k = 0; k < 14; k++) begin
            mode = int'($urandom_range(0, 2));
            if (mode == 0) begin
                p = 0;
                a = W + int'($urandom_range(0, 230));
                h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 12)) : int'($urandom_range(13, 900));
            end else if (mode == 1) begin
                p = int'($urandom_range(1, 300));
                a = p + int'($urandom_range(1, 150));
                h = int'($urandom_range(1, 900));
            end else begin
                p = 0; a = N; h = 0;
            end
            run_txn(p, a, h, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 5) == 0), -1);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
